// File: rtl/eth_crc_pkg.sv
// rtl/eth_crc_pkg.sv - CRC-32 constants, checker state enum and byte-step helper
package eth_crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  // One byte of the reflected CRC, LSB of the byte entering first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_checker_if.sv
// rtl/crc32_checker_if.sv - RX frame stream in, FCS-stripped stream plus verdict out
interface crc32_checker_if;

  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        in_last;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic        out_last;
  logic        out_fcs_good;
  logic        out_fcs_bad;

  modport master (
    output in_data, in_valid, in_last,
    input  out_data, out_valid, out_last, out_fcs_good, out_fcs_bad
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output out_data, out_valid, out_last, out_fcs_good, out_fcs_bad
  );

endinterface

// File: rtl/crc32_step.sv
// rtl/crc32_step.sv - combinational CRC-32 over the valid lanes of one 32-bit beat
module crc32_step
  import eth_crc_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  input  logic [3:0]  valid,
  output logic [31:0] crc_out
);

  // Lane 0 is first on the wire, so it is folded in first
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (valid[i]) begin
        crc_out = crc32_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/crc32_checker.sv
// rtl/crc32_checker.sv - RX FCS checker: CRC over frame+FCS, one-word holdback strips FCS
module crc32_checker
  import eth_crc_pkg::*;
#(
  parameter int          SLICE_LENGTH = 4,
  parameter logic [31:0] INITIAL_CRC  = CRC32_INIT,
  parameter logic [31:0] RESIDUE      = CRC32_RESIDUE
)(
  input  logic            clk,
  input  logic            rst,
  crc32_checker_if.slave  bus
);

  localparam logic [3:0] FULL = 4'((1 << SLICE_LENGTH) - 1);

  state_t      state, state_n;
  logic [31:0] held, held_n;
  logic [31:0] crc, crc_n;
  logic        err, err_n;
  logic [31:0] out_data_q, out_data_n;
  logic [3:0]  out_valid_q, out_valid_n;
  logic        out_last_q, out_last_n;
  logic        out_good_q, out_good_n;
  logic        out_bad_q, out_bad_n;

  logic [31:0] crc_seed;
  logic [31:0] crc_next;
  logic        beat;

  assign beat     = (bus.in_valid != 4'h0);
  assign crc_seed = (state == IDLE) ? INITIAL_CRC : crc;

  crc32_step u_step (
    .crc_in  (crc_seed),
    .data    (bus.in_data),
    .valid   (bus.in_valid),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      held        <= 32'h0;
      crc         <= INITIAL_CRC;
      err         <= 1'b0;
      out_data_q  <= 32'h0;
      out_valid_q <= 4'h0;
      out_last_q  <= 1'b0;
      out_good_q  <= 1'b0;
      out_bad_q   <= 1'b0;
    end else begin
      state       <= state_n;
      held        <= held_n;
      crc         <= crc_n;
      err         <= err_n;
      out_data_q  <= out_data_n;
      out_valid_q <= out_valid_n;
      out_last_q  <= out_last_n;
      out_good_q  <= out_good_n;
      out_bad_q   <= out_bad_n;
    end
  end

  always_comb begin
    state_n     = state;
    held_n      = held;
    crc_n       = crc;
    err_n       = err;
    out_data_n  = out_data_q;
    out_valid_n = 4'h0;
    out_last_n  = 1'b0;
    out_good_n  = 1'b0;
    out_bad_n   = 1'b0;

    if (beat) begin
      unique case (state)
        IDLE: begin
          if (bus.in_last) begin
            // Whole frame fits in the FCS: nothing to deliver, always bad
            out_last_n = 1'b1;
            out_bad_n  = 1'b1;
            err_n      = 1'b0;
          end else begin
            crc_n   = crc_next;
            held_n  = bus.in_data;
            err_n   = (bus.in_valid != FULL);
            state_n = HOLD;
          end
        end
        HOLD: begin
          out_data_n = held;
          if (bus.in_last) begin
            // k bytes in the last beat means the held word's first k bytes are payload
            out_valid_n = bus.in_valid;
            out_last_n  = 1'b1;
            out_good_n  = (crc_next == RESIDUE) && !err;
            out_bad_n   = !((crc_next == RESIDUE) && !err);
            crc_n       = INITIAL_CRC;
            err_n       = 1'b0;
            state_n     = IDLE;
          end else begin
            out_valid_n = FULL;
            held_n      = bus.in_data;
            crc_n       = crc_next;
            err_n       = err || (bus.in_valid != FULL);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_fcs_good = out_good_q;
  assign bus.out_fcs_bad  = out_bad_q;

endmodule
